// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer for one FPAA island switch matrix:
// addresses the cell, times injection/tunnelling pulses, runs an optional measurement, returns a response.
module fg_prog_sequencer #(
    parameter int ROW_W     = 6,
    parameter int COL_W     = 6,
    parameter int ISL_W     = 1,
    parameter int N_ROWS    = 12,
    parameter int N_COLS    = 19,
    parameter int SETUP_CYC = 8,
    parameter int GAP_CYC   = 4,
    parameter int MEAS_TO   = 1024,
    parameter int MEAS_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ISL_W-1:0]  cmd_island,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [COL_W-1:0]  cmd_col,
    input  logic [7:0]        cmd_npulse,
    input  logic [15:0]       cmd_pulse_len,
    input  logic              abort,
    output logic [ISL_W-1:0]  dec_island,
    output logic [ROW_W-1:0]  dec_row,
    output logic [COL_W-1:0]  dec_col,
    output logic              prog_mode,
    output logic              drain_sel_en,
    output logic              gate_sel_en,
    output logic              vinj_pulse,
    output logic              tunnel_en,
    output logic              meas_req,
    input  logic              meas_ack,
    input  logic [MEAS_W-1:0] meas_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [MEAS_W-1:0] rsp_data,
    output logic              busy
);
    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // SETUP | address settle, selects off (break-before-make)
    // PULSE | injection or tunnelling pulse active
    // GAP   | inter-pulse idle, pulse count decremented at end
    // MEAS  | drain-current measurement handshake
    // DISCH | discharge, selects and pulses off
    // RESP  | response held until rsp_ready
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP, S_MEAS, S_DISCH, S_RESP} state_t;

    localparam int TMR_W = 16;
    localparam logic [1:0] OP_INJECT = 2'b00, OP_TUNNEL = 2'b01, OP_MEASURE = 2'b10, OP_INJ_VER = 2'b11;
    localparam logic [1:0] ST_OK = 2'b00, ST_BADADDR = 2'b01, ST_TIMEOUT = 2'b10, ST_ABORTED = 2'b11;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [7:0]         pulse_cnt;
    logic [15:0]        len_q;
    logic [TMR_W-1:0]   tmr, tmr_load;
    logic [1:0]         status_q;
    logic [MEAS_W-1:0]  data_q;
    logic               ready_en;
    logic               accept, bad_addr, abort_act, tmr_tc, sel_on;

    // ready_en keeps cmd_ready low while reset is asserted and until the first clock after release
    assign cmd_ready = (state == S_IDLE) && ready_en;
    assign accept    = cmd_valid && cmd_ready;
    assign bad_addr  = (cmd_op != OP_TUNNEL) &&
                       (({1'b0, cmd_row} >= (ROW_W+1)'(N_ROWS)) || ({1'b0, cmd_col} >= (COL_W+1)'(N_COLS)));
    assign abort_act = abort && (state inside {S_SETUP, S_PULSE, S_GAP, S_MEAS});
    assign tmr_tc    = (tmr == '0);

    always_comb begin
        state_nxt = state;
        tmr_load  = '0;
        case (state)
            S_IDLE:  if (accept) state_nxt = bad_addr ? S_RESP : S_SETUP;
            S_SETUP: begin
                if (abort_act) state_nxt = S_DISCH;
                else if (tmr_tc) begin
                    if (op_q == OP_MEASURE || pulse_cnt == 8'd0)
                        state_nxt = (op_q == OP_MEASURE || op_q == OP_INJ_VER) ? S_MEAS : S_DISCH;
                    else
                        state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (abort_act) state_nxt = S_DISCH;
                else if (tmr_tc) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (abort_act) state_nxt = S_DISCH;
                else if (tmr_tc) begin
                    if (pulse_cnt > 8'd1) state_nxt = S_PULSE;
                    else state_nxt = (op_q == OP_INJ_VER) ? S_MEAS : S_DISCH;
                end
            end
            S_MEAS:  if (abort_act || meas_ack || tmr_tc) state_nxt = S_DISCH;
            S_DISCH: if (tmr_tc) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_SETUP, S_DISCH: tmr_load = TMR_W'(SETUP_CYC - 1);
            S_PULSE:          tmr_load = (len_q == 16'd0) ? '0 : TMR_W'(len_q - 16'd1);
            S_GAP:            tmr_load = TMR_W'(GAP_CYC - 1);
            S_MEAS:           tmr_load = TMR_W'(MEAS_TO - 1);
            default:          tmr_load = '0;
        endcase
    end

    // abort gates the analog drives in the same cycle it is seen
    always_comb begin
        sel_on       = (state inside {S_PULSE, S_GAP, S_MEAS}) && (op_q != OP_TUNNEL) && !abort_act;
        drain_sel_en = sel_on;
        gate_sel_en  = sel_on;
        vinj_pulse   = (state == S_PULSE) && (op_q != OP_TUNNEL) && !abort_act;
        tunnel_en    = (state == S_PULSE) && (op_q == OP_TUNNEL) && !abort_act;
        meas_req     = (state == S_MEAS) && !abort_act;
        prog_mode    = state inside {S_SETUP, S_PULSE, S_GAP, S_MEAS, S_DISCH};
        rsp_valid    = (state == S_RESP);
        busy         = (state != S_IDLE);
        rsp_status   = status_q;
        rsp_data     = data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            tmr        <= '0;
            op_q       <= OP_INJECT;
            pulse_cnt  <= '0;
            len_q      <= '0;
            status_q   <= ST_OK;
            data_q     <= '0;
            dec_island <= '0;
            dec_row    <= '0;
            dec_col    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (state_nxt != state) tmr <= tmr_load;
            else if (!tmr_tc)       tmr <= tmr - 1'b1;

            if (accept) begin
                op_q      <= cmd_op;
                pulse_cnt <= cmd_npulse;
                len_q     <= cmd_pulse_len;
                status_q  <= bad_addr ? ST_BADADDR : ST_OK;
                data_q    <= '0;
                // a rejected address never reaches the decoders
                if (!bad_addr) begin
                    dec_island <= cmd_island;
                    dec_row    <= (cmd_op == OP_TUNNEL) ? '0 : cmd_row;
                    dec_col    <= (cmd_op == OP_TUNNEL) ? '0 : cmd_col;
                end
            end

            if (state == S_GAP && tmr_tc && pulse_cnt != 8'd0) pulse_cnt <= pulse_cnt - 8'd1;

            if (abort_act) status_q <= ST_ABORTED;
            else if (state == S_MEAS) begin
                if (meas_ack)    data_q   <= meas_data;
                else if (tmr_tc) status_q <= ST_TIMEOUT;
            end

            if (state == S_RESP && rsp_ready) begin
                dec_island <= '0;
                dec_row    <= '0;
                dec_col    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Bench for fg_prog_sequencer: directed and random commands checked cycle by cycle
// against a segment-based timeline model of each command.
module tb_fg_prog_sequencer;
    localparam int ROW_W = 6, COL_W = 6, ISL_W = 1, MEAS_W = 12;
    localparam int N_ROWS = 12, N_COLS = 19, SETUP_CYC = 8, GAP_CYC = 4, MEAS_TO = 1024;
    localparam int NO_ACK = 5000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [ISL_W-1:0]  cmd_island;
    logic [ROW_W-1:0]  cmd_row;
    logic [COL_W-1:0]  cmd_col;
    logic [7:0]        cmd_npulse;
    logic [15:0]       cmd_pulse_len;
    logic              abort;
    logic [ISL_W-1:0]  dec_island;
    logic [ROW_W-1:0]  dec_row;
    logic [COL_W-1:0]  dec_col;
    logic              prog_mode, drain_sel_en, gate_sel_en, vinj_pulse, tunnel_en, meas_req;
    logic              meas_ack;
    logic [MEAS_W-1:0] meas_data;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_status;
    logic [MEAS_W-1:0] rsp_data;
    logic              busy;

    int checks = 0;
    int errors = 0;

    fg_prog_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_island(cmd_island),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_npulse(cmd_npulse), .cmd_pulse_len(cmd_pulse_len),
        .abort(abort), .dec_island(dec_island), .dec_row(dec_row), .dec_col(dec_col),
        .prog_mode(prog_mode), .drain_sel_en(drain_sel_en), .gate_sel_en(gate_sel_en),
        .vinj_pulse(vinj_pulse), .tunnel_en(tunnel_en), .meas_req(meas_req),
        .meas_ack(meas_ack), .meas_data(meas_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {prog, vinj, tunnel, drain, gate, meas_req, rsp_valid, busy, cmd_ready}
    function automatic logic [8:0] ctl(input logic prog, input logic vinj, input logic tun,
                                       input logic sel, input logic mreq, input logic rv);
        return {prog, vinj, tun, sel, sel, mreq, rv, 1'b1, 1'b0};
    endfunction

    function automatic logic [8:0] obs_ctl();
        return {prog_mode, vinj_pulse, tunnel_en, drain_sel_en, gate_sel_en, meas_req, rsp_valid, busy, cmd_ready};
    endfunction

    // ack_dly: meas_ack is raised on the (ack_dly+1)-th cycle of meas_req; >= MEAS_TO means never.
    // abort_at: cycle after accept (1-based) on which abort is pulsed; 0 means never.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic isl,
                           input logic [5:0] row, input logic [5:0] col, input logic [7:0] np,
                           input logic [15:0] len, input int ack_dly, input int abort_at,
                           input int hold, input logic [11:0] mdata);
        logic [8:0]  tr[$];
        logic [1:0]  st;
        logic [11:0] dat;
        logic [12:0] dec_exp;
        logic        bad, sel;
        int          pl, mlen, disch_start, mcount;

        bad  = (op != 2'b01) && (int'(row) >= N_ROWS || int'(col) >= N_COLS);
        sel  = (op != 2'b01);
        pl   = (len == 16'd0) ? 1 : int'(len);
        mlen = (ack_dly < MEAS_TO) ? ack_dly + 1 : MEAS_TO;
        st   = 2'b00;
        dat  = '0;
        if (bad) begin
            tr.push_back(ctl(0, 0, 0, 0, 0, 1));
            st = 2'b01;
            dec_exp = '0;
        end else begin
            dec_exp = {isl, (op == 2'b01) ? 6'd0 : row, (op == 2'b01) ? 6'd0 : col};
            repeat (SETUP_CYC) tr.push_back(ctl(1, 0, 0, 0, 0, 0));
            if (op != 2'b10 && np != 8'd0) begin
                for (int p = 0; p < int'(np); p++) begin
                    repeat (pl) tr.push_back(ctl(1, op != 2'b01, op == 2'b01, sel, 0, 0));
                    repeat (GAP_CYC) tr.push_back(ctl(1, 0, 0, sel, 0, 0));
                end
            end
            if (op == 2'b10 || op == 2'b11) begin
                repeat (mlen) tr.push_back(ctl(1, 0, 0, sel, 1, 0));
                if (ack_dly < MEAS_TO) dat = mdata;
                else st = 2'b10;
            end
            disch_start = tr.size() + 1;
            if (abort_at >= 1 && abort_at < disch_start) begin
                while (tr.size() > abort_at - 1) void'(tr.pop_back());
                tr.push_back(ctl(1, 0, 0, 0, 0, 0));
                st  = 2'b11;
                dat = '0;
            end
            repeat (SETUP_CYC) tr.push_back(ctl(1, 0, 0, 0, 0, 0));
            tr.push_back(ctl(0, 0, 0, 0, 0, 1));
        end

        @(negedge clk);
        cmd_op = op; cmd_island = isl; cmd_row = row; cmd_col = col;
        cmd_npulse = np; cmd_pulse_len = len; meas_data = mdata;
        cmd_valid = 1'b1;
        #1 chk({tag, " ready"}, {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_row = 6'($urandom_range(0, 63));
        cmd_col = 6'($urandom_range(0, 63));

        mcount = 0;
        for (int c = 1; c <= tr.size(); c++) begin
            @(negedge clk);
            meas_ack = 1'b0;
            abort = (c == abort_at);
            #1;
            chk($sformatf("%s ctl c%0d", tag, c), {55'd0, obs_ctl()}, {55'd0, tr[c-1]});
            chk($sformatf("%s dec c%0d", tag, c), {51'd0, dec_island, dec_row, dec_col}, {51'd0, dec_exp});
            if (meas_req === 1'b1) begin
                if (mcount == ack_dly) meas_ack = 1'b1;
                mcount++;
            end
        end
        abort = 1'b0;
        meas_ack = 1'b0;
        chk({tag, " status"}, {62'd0, rsp_status}, {62'd0, st});
        chk({tag, " data"}, {52'd0, rsp_data}, {52'd0, dat});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            #1 chk($sformatf("%s hold%0d", tag, h), {48'd0, rsp_valid, cmd_ready, rsp_status, rsp_data},
                   {48'd0, 1'b1, 1'b0, st, dat});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, " idle"}, {47'd0, rsp_valid, busy, cmd_ready, prog_mode, dec_island, dec_row, dec_col},
            {47'd0, 4'b0010, 13'd0});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outA"}, {44'd0, cmd_ready, dec_island, dec_row, dec_col, prog_mode, drain_sel_en,
                             gate_sel_en, vinj_pulse, tunnel_en, meas_req}, 64'd0);
        chk({tag, " outB"}, {48'd0, rsp_valid, rsp_status, rsp_data, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0] rop;
        int         rack, rab;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_island = '0; cmd_row = '0; cmd_col = '0;
        cmd_npulse = '0; cmd_pulse_len = '0; abort = 1'b0; meas_ack = 1'b0; meas_data = '0;
        rsp_ready = 1'b0;
        #2 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_cmd("inject",   2'b00, 1'b0, 6'd3,  6'd5,  8'd2, 16'd3,   NO_ACK, 0,  0, 12'h000);
        run_cmd("inj_ver",  2'b11, 1'b1, 6'd7,  6'd18, 8'd1, 16'd2,   5,      0,  1, 12'hABC);
        run_cmd("badrow",   2'b00, 1'b0, 6'd12, 6'd5,  8'd2, 16'd3,   NO_ACK, 0,  2, 12'h000);
        run_cmd("badcol",   2'b11, 1'b1, 6'd11, 6'd19, 8'd1, 16'd3,   3,      0,  0, 12'h123);
        run_cmd("abort",    2'b00, 1'b1, 6'd2,  6'd4,  8'd1, 16'd100, NO_ACK, 10, 0, 12'h000);
        run_cmd("timeout",  2'b10, 1'b0, 6'd0,  6'd0,  8'd3, 16'd5,   NO_ACK, 0,  0, 12'h5A5);
        run_cmd("tunnel",   2'b01, 1'b1, 6'd40, 6'd50, 8'd1, 16'd10,  NO_ACK, 0,  5, 12'h000);
        run_cmd("np0_inj",  2'b00, 1'b0, 6'd1,  6'd1,  8'd0, 16'd4,   NO_ACK, 0,  0, 12'h000);
        run_cmd("len0",     2'b00, 1'b0, 6'd11, 6'd18, 8'd2, 16'd0,   NO_ACK, 0,  0, 12'h000);
        run_cmd("ack_abort",2'b10, 1'b0, 6'd4,  6'd4,  8'd0, 16'd1,   2,      11, 0, 12'h777);
        run_cmd("abort_dis",2'b00, 1'b0, 6'd4,  6'd4,  8'd1, 16'd1,   NO_ACK, 15, 0, 12'h000);

        for (int n = 0; n < 40; n++) begin
            rop  = 2'($urandom_range(0, 3));
            rack = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 12));
            rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_cmd($sformatf("rnd%0d", n), rop, 1'($urandom_range(0, 1)),
                    6'($urandom_range(0, 15)), 6'($urandom_range(0, 23)),
                    8'($urandom_range(0, 3)), 16'($urandom_range(0, 5)),
                    rack, rab, int'($urandom_range(0, 3)), 12'($urandom));
        end

        // reset in the middle of a long pulse
        @(negedge clk);
        cmd_op = 2'b00; cmd_island = 1'b1; cmd_row = 6'd5; cmd_col = 6'd6;
        cmd_npulse = 8'd1; cmd_pulse_len = 16'd50; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1 chk("midop vinj", {63'd0, vinj_pulse}, 64'd1);
        rst_n = 1'b0;
        #1 chk_all_zero("midop_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_cmd("post_rst", 2'b11, 1'b0, 6'd9, 6'd9, 8'd1, 16'd2, 0, 0, 0, 12'hFED);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
